// File: rtl/processor_8085_single_cycle_if.sv
// Observation bundle for the single-cycle 8085 core: program counter,
// accumulator copy and the ALU second operand, driven by the core and
// consumed by whatever monitors it.
interface processor_8085_single_cycle_if;
   logic [7:0] pc;
   logic [7:0] Accout;
   logic [7:0] alu2_b;

   modport master (output pc, Accout, alu2_b);
   modport slave  (input  pc, Accout, alu2_b);
endinterface

// File: rtl/processor_8085_single_cycle.sv
// Single-cycle 8-bit core running a register-only subset of the 8085 ISA.
// Every rising edge fetches ROM[pc], executes it and writes the result back.
// The register file is deliberately left out of reset so it can be preloaded.

// Seven 8-bit registers B,C,D,E,H,L,A held at indices 0..6.
// Reads are combinational so fetch, execute and write-back fit in one cycle.
module processor_8085_regfile (
   input  logic       clk,
   input  logic       i_we,
   input  logic [2:0] i_wcode,
   input  logic [7:0] i_wdata,
   input  logic [2:0] i_src_code,
   input  logic [2:0] i_dst_code,
   output logic [7:0] o_src,
   output logic [7:0] o_dst,
   output logic [7:0] o_acc
);
   logic [7:0] regfile_8085 [0:6];
   logic [2:0] w_src_idx;
   logic [2:0] w_dst_idx;
   logic [2:0] w_wr_idx;

   // Register codes 000..101 map straight through; 111 (A) lands on index 6.
   // Code 110 (M) also folds onto 6, but the decoder never writes with it.
   assign w_src_idx = (i_src_code[2:1] == 2'b11) ? 3'd6 : i_src_code;
   assign w_dst_idx = (i_dst_code[2:1] == 2'b11) ? 3'd6 : i_dst_code;
   assign w_wr_idx  = (i_wcode[2:1]    == 2'b11) ? 3'd6 : i_wcode;

   assign o_src = regfile_8085[w_src_idx];
   assign o_dst = regfile_8085[w_dst_idx];
   assign o_acc = regfile_8085[6];

   // Single write port, no reset so preloaded contents survive rst.
   always_ff @(posedge clk) begin
      if (i_we) begin
         regfile_8085[w_wr_idx] <= i_wdata;
      end
   end
endmodule

module processor_8085_single_cycle #(
   parameter string PROG_FILE  = "program.hex",
   parameter int    IMEM_DEPTH = 32            // power of two, at most 256
) (
   input  logic                              clk,
   input  logic                              rst,
   output logic                              cy,
   output logic                              z,
   output logic [7:0]                        ACC,
   processor_8085_single_cycle_if.master     o_dbg
);
   localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

   logic [7:0]    r_rom [0:IMEM_DEPTH-1];
   logic [7:0]    pc;
   logic          r_cy;
   logic          r_z;

   logic [AW-1:0] w_rom_addr;
   logic [7:0]    w_op;
   logic [2:0]    w_src_code;
   logic [2:0]    w_dst_code;
   logic          w_src_m;
   logic          w_dst_m;
   logic [7:0]    w_src_val;
   logic [7:0]    w_dst_val;
   logic [7:0]    Accout;
   logic [7:0]    alu2_b;
   logic          w_halt;
   logic          w_we;
   logic [2:0]    w_wcode;
   logic [7:0]    w_wdata;
   logic          w_cy_next;
   logic          w_z_next;
   logic [8:0]    w_res9;

   // ROM is indexed modulo its depth by taking the low pc bits.
   assign w_rom_addr = pc[AW-1:0];
   assign w_op       = r_rom[w_rom_addr];
   assign w_src_code = w_op[2:0];
   assign w_dst_code = w_op[5:3];
   assign w_src_m    = (w_src_code == 3'b110);
   assign w_dst_m    = (w_dst_code == 3'b110);

   processor_8085_regfile RF1 (
      .clk        (clk),
      .i_we       (w_we & ~rst),
      .i_wcode    (w_wcode),
      .i_wdata    (w_wdata),
      .i_src_code (w_src_code),
      .i_dst_code (w_dst_code),
      .o_src      (w_src_val),
      .o_dst      (w_dst_val),
      .o_acc      (Accout)
   );

   // Decode and execute the current opcode: ALU result, flags and write-back.
   always_comb begin
      w_halt    = 1'b0;
      w_we      = 1'b0;
      w_wcode   = w_dst_code;
      w_wdata   = 8'h00;
      w_cy_next = r_cy;
      w_z_next  = r_z;
      w_res9    = 9'h000;
      alu2_b    = w_src_val;

      if (w_op == 8'h76) begin
         w_halt = 1'b1;
      end else begin
         case (w_op[7:6])
            2'b01: begin
               // MOV d,s
               if (!w_src_m && !w_dst_m) begin
                  w_we    = 1'b1;
                  w_wcode = w_dst_code;
                  w_wdata = w_src_val;
               end
            end
            2'b10: begin
               // ALU A,s; bit 8 of the 9-bit result is carry or borrow
               if (!w_src_m) begin
                  case (w_op[5:3])
                     3'b000:  w_res9 = {1'b0, Accout} + {1'b0, alu2_b};
                     3'b001:  w_res9 = {1'b0, Accout} + {1'b0, alu2_b} + {8'h00, r_cy};
                     3'b010:  w_res9 = {1'b0, Accout} - {1'b0, alu2_b};
                     3'b011:  w_res9 = {1'b0, Accout} - {1'b0, alu2_b} - {8'h00, r_cy};
                     3'b100:  w_res9 = {1'b0, Accout & alu2_b};
                     3'b101:  w_res9 = {1'b0, Accout ^ alu2_b};
                     3'b110:  w_res9 = {1'b0, Accout | alu2_b};
                     default: w_res9 = {1'b0, Accout} - {1'b0, alu2_b};
                  endcase
                  w_cy_next = w_res9[8];
                  w_z_next  = (w_res9[7:0] == 8'h00);
                  w_we      = (w_op[5:3] != 3'b111);
                  w_wcode   = 3'b111;
                  w_wdata   = w_res9[7:0];
               end
            end
            2'b00: begin
               // INR d / DCR d; carry untouched
               if (w_op[2:1] == 2'b10) begin
                  alu2_b = 8'h01;
                  if (!w_dst_m) begin
                     w_res9   = w_op[0] ? ({1'b0, w_dst_val} - 9'd1)
                                        : ({1'b0, w_dst_val} + 9'd1);
                     w_z_next = (w_res9[7:0] == 8'h00);
                     w_we     = 1'b1;
                     w_wcode  = w_dst_code;
                     w_wdata  = w_res9[7:0];
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Program counter and flags; HLT simply freezes pc on itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc   <= 8'h00;
         r_cy <= 1'b0;
         r_z  <= 1'b0;
      end else begin
         if (!w_halt) begin
            pc <= pc + 8'd1;
         end
         r_cy <= w_cy_next;
         r_z  <= w_z_next;
      end
   end

   assign cy  = r_cy;
   assign z   = r_z;
   assign ACC = Accout;

   assign o_dbg.pc     = pc;
   assign o_dbg.Accout = Accout;
   assign o_dbg.alu2_b = alu2_b;
endmodule

// File: tb/tb_processor_8085_single_cycle.sv
// Bench for the single-cycle 8085 core: directed scenarios with fixed
// expectations followed by random programs checked against an ISA-level model.
module tb_processor_8085_single_cycle;
   logic       clk;
   logic       rst;
   logic       cy;
   logic       z;
   logic [7:0] ACC;

   processor_8085_single_cycle_if dbg_if ();

   processor_8085_single_cycle #(
      .PROG_FILE  (""),
      .IMEM_DEPTH (32)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .cy    (cy),
      .z     (z),
      .ACC   (ACC),
      .o_dbg (dbg_if)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] prog [0:31];
   int         m_reg [0:7];   // indexed by register code, A at 7
   int         m_cy;
   int         m_z;
   int         m_pc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic default_regs();
      for (int i = 0; i < 6; i++) m_reg[i] = i + 1;
      m_reg[6] = 0;
      m_reg[7] = 7;
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 32; i++) prog[i] = 8'h00;
   endtask

   // Load ROM and registers, then give the core one reset edge.
   task automatic start_scenario();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 32; i++) dut.r_rom[i] = prog[i];
      for (int i = 0; i < 6; i++) dut.RF1.regfile_8085[i] = 8'(m_reg[i]);
      dut.RF1.regfile_8085[6] = 8'(m_reg[7]);
      @(negedge clk);
      rst  = 1'b0;
      m_pc = 0;
      m_cy = 0;
      m_z  = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst = 1'b1;
      step();
   endtask

   // ISA-level reference: one instruction of the register-only 8085 subset.
   task automatic model_step();
      int op, s, d, a, b, r;
      op = int'(prog[m_pc % 32]);
      s  = op % 8;
      d  = (op / 8) % 8;
      if (op == 'h76) return;
      if (op >= 64 && op < 128) begin
         if (s != 6 && d != 6) m_reg[d] = m_reg[s];
      end else if (op >= 128 && op < 192) begin
         if (s != 6) begin
            a = m_reg[7];
            b = m_reg[s];
            case (d)
               0: r = a + b;
               1: r = a + b + m_cy;
               2: r = a - b;
               3: r = a - b - m_cy;
               4: r = a & b;
               5: r = a ^ b;
               6: r = a | b;
               default: r = a - b;
            endcase
            m_cy = (d < 4 || d == 7) ? int'(r > 255 || r < 0) : 0;
            m_z  = int'((r & 255) == 0);
            if (d != 7) m_reg[7] = r & 255;
         end
      end else if (op < 64 && (op % 8) >= 4 && (op % 8) <= 5) begin
         if (d != 6) begin
            m_reg[d] = (op % 2 == 1) ? (m_reg[d] + 255) % 256 : (m_reg[d] + 1) % 256;
            m_z      = int'(m_reg[d] == 0);
         end
      end
      m_pc = (m_pc + 1) % 256;
   endtask

   initial begin
      rst = 1'b1;

      // 1) ADD B
      default_regs(); clear_prog();
      prog[0] = 8'h80;
      start_scenario();
      chk("s1_reset_pc", dbg_if.pc, 8'h00);
      chk("s1_reset_cy", {7'd0, cy}, 8'h00);
      chk("s1_reset_z", {7'd0, z}, 8'h00);
      chk("s1_reset_acc", ACC, 8'h07);
      step();
      chk("s1_acc", ACC, 8'h08);
      chk("s1_cy", {7'd0, cy}, 8'h00);
      chk("s1_z", {7'd0, z}, 8'h00);
      chk("s1_pc", dbg_if.pc, 8'h01);

      // 2) SUB A, DCR A
      default_regs(); clear_prog();
      prog[0] = 8'h97; prog[1] = 8'h3D;
      start_scenario();
      chk("s2_alu2b_sub", dbg_if.alu2_b, 8'h07);
      step();
      chk("s2_sub_acc", ACC, 8'h00);
      chk("s2_sub_z", {7'd0, z}, 8'h01);
      chk("s2_sub_cy", {7'd0, cy}, 8'h00);
      chk("s2_alu2b_dcr", dbg_if.alu2_b, 8'h01);
      step();
      chk("s2_dcr_acc", ACC, 8'hFF);
      chk("s2_dcr_z", {7'd0, z}, 8'h00);
      chk("s2_dcr_cy", {7'd0, cy}, 8'h00);

      // 3) A=FF: ADD B wraps, then ADC B consumes the carry
      default_regs(); clear_prog();
      m_reg[7] = 255;
      prog[0] = 8'h80; prog[1] = 8'h88;
      start_scenario();
      step();
      chk("s3_add_acc", ACC, 8'h00);
      chk("s3_add_cy", {7'd0, cy}, 8'h01);
      chk("s3_add_z", {7'd0, z}, 8'h01);
      step();
      chk("s3_adc_acc", ACC, 8'h02);
      chk("s3_adc_cy", {7'd0, cy}, 8'h00);
      chk("s3_adc_z", {7'd0, z}, 8'h00);

      // 4) MOV B,A; MOV A,B
      default_regs(); clear_prog();
      prog[0] = 8'h47; prog[1] = 8'h78;
      start_scenario();
      step();
      chk("s4_mov_b", dut.RF1.regfile_8085[0], 8'h07);
      chk("s4_mov1_acc", ACC, 8'h07);
      step();
      chk("s4_mov2_acc", ACC, 8'h07);
      chk("s4_mov_cy", {7'd0, cy}, 8'h00);
      chk("s4_mov_z", {7'd0, z}, 8'h00);

      // 5) CMP B, ANA B
      default_regs(); clear_prog();
      prog[0] = 8'hB8; prog[1] = 8'hA0;
      start_scenario();
      step();
      chk("s5_cmp_acc", ACC, 8'h07);
      chk("s5_cmp_cy", {7'd0, cy}, 8'h00);
      chk("s5_cmp_z", {7'd0, z}, 8'h00);
      step();
      chk("s5_ana_acc", ACC, 8'h01);
      chk("s5_ana_cy", {7'd0, cy}, 8'h00);

      // 6) NOP, HLT, ADD B: halt holds, reset leaves halt
      default_regs(); clear_prog();
      prog[0] = 8'h00; prog[1] = 8'h76; prog[2] = 8'h80;
      start_scenario();
      step();
      chk("s6_pc_nop", dbg_if.pc, 8'h01);
      step();
      chk("s6_pc_hlt1", dbg_if.pc, 8'h01);
      step();
      chk("s6_pc_hlt2", dbg_if.pc, 8'h01);
      chk("s6_acc_hlt", ACC, 8'h07);
      reset_pulse();
      chk("s6_rst_pc", dbg_if.pc, 8'h00);
      chk("s6_rst_cy", {7'd0, cy}, 8'h00);
      chk("s6_rst_z", {7'd0, z}, 8'h00);
      @(negedge clk); rst = 1'b0;
      step();
      chk("s6_run_pc", dbg_if.pc, 8'h01);

      // 6b) flags frozen by HLT, cleared by reset
      default_regs(); clear_prog();
      prog[0] = 8'h97; prog[1] = 8'h76;
      start_scenario();
      step();
      chk("s6b_z_set", {7'd0, z}, 8'h01);
      step();
      chk("s6b_z_hlt", {7'd0, z}, 8'h01);
      chk("s6b_pc_hlt", dbg_if.pc, 8'h01);
      reset_pulse();
      chk("s6b_rst_z", {7'd0, z}, 8'h00);
      chk("s6b_rst_pc", dbg_if.pc, 8'h00);

      // Random programs against the reference model; 40 steps wraps the ROM.
      for (int rnd = 0; rnd < 20; rnd++) begin
         for (int i = 0; i < 6; i++) m_reg[i] = int'($urandom_range(0, 255));
         m_reg[6] = 0;
         m_reg[7] = int'($urandom_range(0, 255));
         for (int i = 0; i < 32; i++) begin
            case ($urandom_range(0, 4))
               0:       prog[i] = 8'h40 | 8'($urandom_range(0, 63));
               1, 2:    prog[i] = 8'h80 | 8'($urandom_range(0, 63));
               3:       prog[i] = {2'b00, 3'($urandom_range(0, 7)), 2'b10, 1'($urandom_range(0, 1))};
               default: prog[i] = 8'($urandom_range(0, 255));
            endcase
         end
         start_scenario();
         chk("rnd_reset_pc", dbg_if.pc, 8'h00);
         chk("rnd_reset_acc", ACC, 8'(m_reg[7]));
         for (int k = 0; k < 40; k++) begin
            model_step();
            step();
            chk($sformatf("rnd%0d_%0d_pc", rnd, k), dbg_if.pc, 8'(m_pc));
            chk($sformatf("rnd%0d_%0d_acc", rnd, k), ACC, 8'(m_reg[7]));
            chk($sformatf("rnd%0d_%0d_cy", rnd, k), {7'd0, cy}, 8'(m_cy));
            chk($sformatf("rnd%0d_%0d_z", rnd, k), {7'd0, z}, 8'(m_z));
         end
         for (int i = 0; i < 6; i++) begin
            chk($sformatf("rnd%0d_reg%0d", rnd, i), dut.RF1.regfile_8085[i], 8'(m_reg[i]));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
